gated_channel_current: RTL and testbench
========================================

Name: gated_channel_current

Overview:
- Parametrised Hodgkin-Huxley ionic current unit: I = g_max * m^M_EXP * h^H_EXP * (V - E_rev), in signed fixed point.
- Serves Na (M_EXP=3, H_EXP=1), K (M_EXP=4, H_EXP=0) and leak (0, 0) channels from one block.
- Sits between the gate-variable updaters and the membrane integrator.
- Adds over the previous sodium block: runtime g_max/E_rev, gate clamping, a multi-cycle shared multiplier, saturation flag and a valid/ready handshake.

Parameters:
- WIDTH, 16, signed word width of all data ports.
- FRAC, 8, fractional bits; 1.0 = 1<<FRAC.
- M_EXP, 3, activation-gate exponent, 0..7.
- H_EXP, 1, inactivation-gate exponent, 0..7.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- in_valid  in  1  operand set valid.
- in_ready  out  1  block can accept operands.
- v  in  WIDTH  membrane potential.
- m  in  WIDTH  activation gate.
- h  in  WIDTH  inactivation gate; ignored when H_EXP=0.
- g_max  in  WIDTH  maximal conductance.
- e_rev  in  WIDTH  reversal potential.
- i_out  out  WIDTH  channel current, held until the next result.
- out_valid  out  1  one-cycle pulse, i_out updated.
- sat  out  1  qualifies out_valid: saturation occurred in this result.

Behaviour:
- Reset (rst=0, async): state IDLE, i_out=0, out_valid=0, sat=0, accumulator=0, step counter=0. Reset mid-computation aborts the computation with no output pulse.
- States: IDLE, MUL, DONE. in_ready = (state==IDLE) and rst deasserted.
- IDLE, accept edge T0 (in_valid & in_ready):
  - latch gates clamped to [0, 1<<FRAC], giving mc and hc;
  - latch d = sat(v - e_rev), computed WIDTH+1 wide;
  - acc <= g_max; sat_flag <= d saturated;
  - go to MUL with K = M_EXP + H_EXP + 1 steps.
- MUL, edges T1..TK, one multiply per edge:
  - order: mc M_EXP times, then hc H_EXP times, then d last;
  - acc <= sat(arith_shift_right(acc*operand, FRAC));
  - product is 2*WIDTH wide; shift truncates toward -infinity;
  - sat_flag |= step saturated;
  - after step K go to DONE.
- Saturation: clip to [-(2^(WIDTH-1)), 2^(WIDTH-1)-1].
- DONE, edge TK+1: i_out <= acc, sat <= sat_flag, out_valid <= 1; go to IDLE.
- out_valid is 1 for exactly one cycle.
- Latency: accept edge to out_valid = K+1 edges; defaults give K=5, latency 6.
- in_ready returns high the cycle after out_valid rises. Minimum issue interval is K+2 cycles.
- in_valid while busy: ignored; the source holds it until accepted.
- Operands changing while busy have no effect.
- M_EXP=H_EXP=0: K=1, only the d multiply runs (leak channel).
- Gate clamp: negative -> 0; above 1.0 -> 1.0. Clamping alone does not set sat.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package/header chan_pkg: FRAC_ONE constant, state encodings, and the saturate function (shared with the gate updaters and membrane integrator).
- Sub-module fx_mul_sat:
  - combinational signed WIDTH x WIDTH multiply, >>FRAC, saturate;
  - outputs result and ovf.
- gated_channel_current holds the FSM, step counter, operand mux and registers.

Test Plan (defaults WIDTH=16, FRAC=8, M_EXP=3, H_EXP=1):
- Basic Na: g_max=256, m=128, h=256, v=0, e_rev=12800 -> exactly 6 cycles after accept, out_valid pulses with i_out=-1600, sat=0.
- Overflow: g_max=30720, m=h=256, v=25600, e_rev=-6912 -> i_out=32767, sat=1. Mirror case with v=-25600, e_rev=6912 -> i_out=-32768, sat=1.
- Clamp: m=-64 (g_max=256, h=256, v=2560, e_rev=0) -> i_out=0. m=384, same other values -> i_out=2560, sat=0.
- Handshake, two back-to-back requests:
  - in_valid held high throughout; in_ready low for cycles T0+1..T0+6;
  - the second set is accepted on the first edge in_ready=1;
  - two out_valid pulses, 7 cycles apart.
- Reset: assert rst=0 at T3 of a computation -> i_out=0, out_valid=0 immediately. After release, in_ready=1 and no stale result pulse.
- Leak build (M_EXP=0, H_EXP=0): g_max=77, v=-16640, e_rev=-13824 -> out_valid 2 edges after accept, i_out=-847.

Source files
------------

// File: rtl/chan_pkg.sv
// Shared definitions for the ionic-channel datapath blocks: fixed-point
// constants, FSM state encodings and the common saturation function.
package chan_pkg;

   localparam int FRAC_DEFAULT = 8;
   localparam int FRAC_ONE     = 1 << FRAC_DEFAULT;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DONE = 2'd2
   } chan_state_e;

   // Clip a sign-extended value to the signed range of a w-bit word.
   function automatic logic signed [63:0] saturate(input logic signed [63:0] x,
                                                   input int w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (x > hi) return hi;
      if (x < lo) return lo;
      return x;
   endfunction

endpackage

// File: rtl/fx_mul_sat.sv
// Combinational signed fixed-point multiply: (a*b) >>> FRAC, saturated to WIDTH.
// ovf flags that the clip changed the value.
module fx_mul_sat
   import chan_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int FRAC  = FRAC_DEFAULT
) (
   input  logic signed [WIDTH-1:0] a,
   input  logic signed [WIDTH-1:0] b,
   output logic signed [WIDTH-1:0] y,
   output logic                    ovf
);

   logic signed [2*WIDTH-1:0] prod;
   logic signed [2*WIDTH-1:0] shifted;
   logic signed [63:0]        wide;
   logic signed [63:0]        clip;

   assign prod    = a * b;
   // Arithmetic shift floors toward -infinity.
   assign shifted = prod >>> FRAC;
   assign wide    = 64'(shifted);
   assign clip    = saturate(wide, WIDTH);
   assign y       = clip[WIDTH-1:0];
   assign ovf     = (clip != wide);

endmodule

// File: rtl/gated_channel_current.sv
// Hodgkin-Huxley channel current I = g_max * m^M_EXP * h^H_EXP * (v - e_rev),
// evaluated one multiply per cycle through a single shared fx_mul_sat.
module gated_channel_current
   import chan_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int FRAC  = FRAC_DEFAULT,
   parameter int M_EXP = 3,
   parameter int H_EXP = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [WIDTH-1:0] v,
   input  logic signed [WIDTH-1:0] m,
   input  logic signed [WIDTH-1:0] h,
   input  logic signed [WIDTH-1:0] g_max,
   input  logic signed [WIDTH-1:0] e_rev,
   output logic signed [WIDTH-1:0] i_out,
   output logic                    out_valid,
   output logic                    sat,
   output chan_state_e             dbg_state
);

   localparam logic [3:0]              LAST_STEP = 4'(M_EXP + H_EXP);
   localparam logic signed [WIDTH-1:0] ONE       = WIDTH'(1 << FRAC);

   chan_state_e             state, state_nx;
   logic [3:0]              step;
   logic signed [WIDTH-1:0] mc, hc, d, acc;
   logic signed [WIDTH-1:0] operand, mul_y;
   logic                    mul_ovf, sat_flag, accept;
   logic signed [WIDTH:0]   d_full;
   logic signed [63:0]      d_wide, d_clip;
   logic                    d_ovf;

   function automatic logic signed [WIDTH-1:0] clamp_gate(input logic signed [WIDTH-1:0] x);
      if (x < 0)   return '0;
      if (x > ONE) return ONE;
      return x;
   endfunction

   // Handshake: an operand set transfers on a rising edge where in_valid and
   // in_ready are both high; the source holds in_valid until that edge.
   assign in_ready  = (state == ST_IDLE) && rst;
   assign accept    = in_valid && in_ready;
   assign dbg_state = state;

   assign d_full = $signed({v[WIDTH-1], v}) - $signed({e_rev[WIDTH-1], e_rev});
   assign d_wide = 64'(d_full);
   assign d_clip = saturate(d_wide, WIDTH);
   assign d_ovf  = (d_clip != d_wide);

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: if (accept) state_nx = ST_MUL;
         ST_MUL:  if (step == LAST_STEP) state_nx = ST_DONE;
         ST_DONE: state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   // Gate powers first, driving force last.
   always_comb begin
      operand = d;
      if (int'(step) < M_EXP)              operand = mc;
      else if (int'(step) < M_EXP + H_EXP) operand = hc;
   end

   fx_mul_sat #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul (
      .a   (acc),
      .b   (operand),
      .y   (mul_y),
      .ovf (mul_ovf)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         step      <= '0;
         mc        <= '0;
         hc        <= '0;
         d         <= '0;
         acc       <= '0;
         sat_flag  <= 1'b0;
         i_out     <= '0;
         sat       <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  mc       <= clamp_gate(m);
                  hc       <= clamp_gate(h);
                  d        <= d_clip[WIDTH-1:0];
                  acc      <= g_max;
                  sat_flag <= d_ovf;
                  step     <= '0;
               end
            end
            ST_MUL: begin
               acc      <= mul_y;
               sat_flag <= sat_flag | mul_ovf;
               step     <= step + 4'd1;
            end
            ST_DONE: begin
               i_out     <= acc;
               sat       <= sat_flag;
               out_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_gated_channel_current.sv
// Directed bench for gated_channel_current: Na build plus a leak build.
module tb_gated_channel_current;
  import chan_pkg::*;

  localparam int W = 16;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_valid_l = 1'b0;
  logic                in_ready, in_ready_l;
  logic signed [W-1:0] v = '0, m = '0, h = '0, g_max = '0, e_rev = '0;
  logic signed [W-1:0] i_out, i_out_l;
  logic                out_valid, out_valid_l, sat, sat_l;
  chan_state_e         dbg_state, dbg_state_l;

  int errors = 0;
  int checks = 0;

  gated_channel_current #(.WIDTH(W), .FRAC(8), .M_EXP(3), .H_EXP(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .v(v), .m(m), .h(h), .g_max(g_max), .e_rev(e_rev),
    .i_out(i_out), .out_valid(out_valid), .sat(sat), .dbg_state(dbg_state)
  );

  gated_channel_current #(.WIDTH(W), .FRAC(8), .M_EXP(0), .H_EXP(0)) dut_leak (
    .clk(clk), .rst(rst), .in_valid(in_valid_l), .in_ready(in_ready_l),
    .v(v), .m(m), .h(h), .g_max(g_max), .e_rev(e_rev),
    .i_out(i_out_l), .out_valid(out_valid_l), .sat(sat_l), .dbg_state(dbg_state_l)
  );

  always #5 clk = ~clk;

  // Driver: present operands and return #1 after the accept edge (T0).
  task automatic issue(input logic signed [W-1:0] gm, mv, hv, vv, ev);
    int n;
    @(negedge clk);
    g_max = gm; m = mv; h = hv; v = vv; e_rev = ev;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      errors++;
      $display("FAIL issue_timeout: in_ready=%0b required 1", in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Driver: count edges from T0 until out_valid, capturing the result.
  task automatic wait_out(output int cyc, output logic signed [W-1:0] res, output logic s);
    cyc = -1; res = '0; s = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        cyc = n; res = i_out; s = sat;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #12;
    checks++; if (i_out !== 16'sd0) begin errors++; $display("FAIL reset_i_out: got %0d want 0", i_out); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    checks++; if (sat !== 1'b0) begin errors++; $display("FAIL reset_sat: got %0b want 0", sat); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_low: got %0b want 0", in_ready); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_high: got %0b want 1", in_ready); end
  endtask

  task automatic test_basic_na;
    int cyc; logic signed [W-1:0] res; logic s;
    issue(16'sd256, 16'sd128, 16'sd256, 16'sd0, 16'sd12800);
    wait_out(cyc, res, s);
    checks++; if (cyc !== 6) begin errors++; $display("FAIL na_latency: got %0d want 6", cyc); end
    checks++; if (res !== -16'sd1600) begin errors++; $display("FAIL na_i_out: got %0d want -1600", res); end
    checks++; if (s !== 1'b0) begin errors++; $display("FAIL na_sat: got %0b want 0", s); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL na_pulse_width: got %0b want 0", out_valid); end
    checks++; if (i_out !== -16'sd1600) begin errors++; $display("FAIL na_hold: got %0d want -1600", i_out); end
  endtask

  task automatic test_overflow;
    int cyc; logic signed [W-1:0] res; logic s;
    issue(16'sd30720, 16'sd256, 16'sd256, 16'sd25600, -16'sd6912);
    wait_out(cyc, res, s);
    checks++; if (res !== 16'sd32767) begin errors++; $display("FAIL ovf_pos_i_out: got %0d want 32767", res); end
    checks++; if (s !== 1'b1) begin errors++; $display("FAIL ovf_pos_sat: got %0b want 1", s); end
    issue(16'sd30720, 16'sd256, 16'sd256, -16'sd25600, 16'sd6912);
    wait_out(cyc, res, s);
    checks++; if (res !== -16'sd32768) begin errors++; $display("FAIL ovf_neg_i_out: got %0d want -32768", res); end
    checks++; if (s !== 1'b1) begin errors++; $display("FAIL ovf_neg_sat: got %0b want 1", s); end
  endtask

  task automatic test_clamp;
    int cyc; logic signed [W-1:0] res; logic s;
    issue(16'sd256, -16'sd64, 16'sd256, 16'sd2560, 16'sd0);
    wait_out(cyc, res, s);
    checks++; if (res !== 16'sd0) begin errors++; $display("FAIL clamp_neg_i_out: got %0d want 0", res); end
    checks++; if (s !== 1'b0) begin errors++; $display("FAIL clamp_neg_sat: got %0b want 0", s); end
    issue(16'sd256, 16'sd384, 16'sd256, 16'sd2560, 16'sd0);
    wait_out(cyc, res, s);
    checks++; if (res !== 16'sd2560) begin errors++; $display("FAIL clamp_hi_i_out: got %0d want 2560", res); end
    checks++; if (s !== 1'b0) begin errors++; $display("FAIL clamp_hi_sat: got %0b want 0", s); end
  endtask

  // in_valid held high; second operand set is presented while the first is busy.
  task automatic test_back_to_back;
    int pulses = 0;
    int first_at = -1, second_at = -1;
    logic exp_rdy;
    @(negedge clk);
    g_max = 16'sd256; m = 16'sd128; h = 16'sd256; v = 16'sd0; e_rev = 16'sd12800;
    in_valid = 1'b1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_t0: got %0b want 1", in_ready); end
    @(posedge clk); #1;
    g_max = 16'sd256; m = 16'sd384; h = 16'sd256; v = 16'sd2560; e_rev = 16'sd0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_c0: got %0b want 0", in_ready); end
    for (int n = 1; n <= 15; n++) begin
      @(posedge clk); #1;
      if (n <= 7) begin
        exp_rdy = (n == 6);
        checks++;
        if (in_ready !== exp_rdy) begin
          errors++; $display("FAIL b2b_ready_c%0d: got %0b want %0b", n, in_ready, exp_rdy);
        end
      end
      if (n == 7) in_valid = 1'b0;
      if (out_valid) begin
        pulses++;
        if (first_at < 0) begin
          first_at = n;
          checks++; if (i_out !== -16'sd1600) begin errors++; $display("FAIL b2b_first_i_out: got %0d want -1600", i_out); end
        end else begin
          second_at = n;
          checks++; if (i_out !== 16'sd2560) begin errors++; $display("FAIL b2b_second_i_out: got %0d want 2560", i_out); end
        end
      end
    end
    checks++; if (pulses !== 2) begin errors++; $display("FAIL b2b_pulses: got %0d want 2", pulses); end
    checks++; if (first_at !== 6) begin errors++; $display("FAIL b2b_first_at: got %0d want 6", first_at); end
    checks++; if (second_at - first_at !== 7) begin errors++; $display("FAIL b2b_spacing: got %0d want 7", second_at - first_at); end
  endtask

  task automatic test_reset_mid;
    int pulses = 0;
    issue(16'sd256, 16'sd128, 16'sd256, 16'sd0, 16'sd12800);
    repeat (2) @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checks++; if (i_out !== 16'sd0) begin errors++; $display("FAIL midrst_i_out: got %0d want 0", i_out); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %0b want 0", out_valid); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL midrst_state: got %0d want %0d", dbg_state, ST_IDLE); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %0b want 1", in_ready); end
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_stale_pulse: got %0d want 0", pulses); end
  endtask

  task automatic test_leak;
    int cyc = -1;
    logic signed [W-1:0] res = '0;
    logic s = 1'b0;
    @(negedge clk);
    g_max = 16'sd77; m = 16'sd100; h = 16'sd100; v = -16'sd16640; e_rev = -16'sd13824;
    in_valid_l = 1'b1;
    checks++; if (in_ready_l !== 1'b1) begin errors++; $display("FAIL leak_ready: got %0b want 1", in_ready_l); end
    @(posedge clk);
    #1 in_valid_l = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      if (out_valid_l) begin cyc = n; res = i_out_l; s = sat_l; break; end
    end
    checks++; if (cyc !== 2) begin errors++; $display("FAIL leak_latency: got %0d want 2", cyc); end
    checks++; if (res !== -16'sd847) begin errors++; $display("FAIL leak_i_out: got %0d want -847", res); end
    checks++; if (s !== 1'b0) begin errors++; $display("FAIL leak_sat: got %0b want 0", s); end
  endtask

  initial begin
    test_reset;
    test_basic_na;
    test_overflow;
    test_clamp;
    test_back_to_back;
    test_reset_mid;
    test_leak;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
